// File: rtl/hex_scroller_pkg.sv
// Shared constants for the scrolling 7-segment message display:
// character codes, active-low segment patterns (bit 0 = a .. bit 6 = g) and the pos width helper.
package hex_scroller_pkg;

  localparam logic [4:0] CH_0     = 5'd0;
  localparam logic [4:0] CH_1     = 5'd1;
  localparam logic [4:0] CH_2     = 5'd2;
  localparam logic [4:0] CH_3     = 5'd3;
  localparam logic [4:0] CH_4     = 5'd4;
  localparam logic [4:0] CH_5     = 5'd5;
  localparam logic [4:0] CH_6     = 5'd6;
  localparam logic [4:0] CH_7     = 5'd7;
  localparam logic [4:0] CH_8     = 5'd8;
  localparam logic [4:0] CH_9     = 5'd9;
  localparam logic [4:0] CH_A     = 5'd10;
  localparam logic [4:0] CH_B     = 5'd11;
  localparam logic [4:0] CH_C     = 5'd12;
  localparam logic [4:0] CH_D     = 5'd13;
  localparam logic [4:0] CH_E     = 5'd14;
  localparam logic [4:0] CH_F     = 5'd15;
  localparam logic [4:0] CH_G     = 5'd16;
  localparam logic [4:0] CH_P     = 5'd17;
  localparam logic [4:0] CH_H     = 5'd18;
  localparam logic [4:0] CH_L     = 5'd19;
  localparam logic [4:0] CH_U     = 5'd20;
  localparam logic [4:0] CH_MINUS = 5'd21;
  localparam logic [4:0] CH_BLANK = 5'd31;

  // Patterns are written gfedcba, 0 = segment lit.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned pos_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational decoder from a 5-bit character code to active-low a..g segments.
module seg7_char_decoder
  import hex_scroller_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_0:     seg = SEG_0;
      CH_1:     seg = SEG_1;
      CH_2:     seg = SEG_2;
      CH_3:     seg = SEG_3;
      CH_4:     seg = SEG_4;
      CH_5:     seg = SEG_5;
      CH_6:     seg = SEG_6;
      CH_7:     seg = SEG_7;
      CH_8:     seg = SEG_8;
      CH_9:     seg = SEG_9;
      CH_A:     seg = SEG_A;
      CH_B:     seg = SEG_B;
      CH_C:     seg = SEG_C;
      CH_D:     seg = SEG_D;
      CH_E:     seg = SEG_E;
      CH_F:     seg = SEG_F;
      CH_G:     seg = SEG_G;
      CH_P:     seg = SEG_P;
      CH_H:     seg = SEG_H;
      CH_L:     seg = SEG_L;
      CH_U:     seg = SEG_U;
      CH_MINUS: seg = SEG_MINUS;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a loaded character message across NUM_DIGITS 7-segment digits,
// advancing on an enabled periodic tick or on a manual step edge.
module hex_scroller
  import hex_scroller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic                              CLOCK_50,
  input  logic                              RESET,
  input  logic [5*MSG_LEN-1:0]              msg,
  input  logic                              load,
  input  logic                              en,
  input  logic                              dir,
  input  logic                              step,
  output logic [7*NUM_DIGITS-1:0]           hex,
  output logic [pos_width(MSG_LEN)-1:0]     pos,
  output logic                              wrap
);

  localparam int unsigned POS_W = pos_width(MSG_LEN);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

  logic [CNT_W-1:0]        cnt;
  logic [POS_W-1:0]        offset;
  logic [POS_W-1:0]        offset_next;
  logic                    wrap_next;
  logic [5*MSG_LEN-1:0]    msg_reg;
  logic                    step_q;
  logic                    step_prev;
  logic                    tick;
  logic                    step_req;
  logic                    advance;
  logic [7*NUM_DIGITS-1:0] hex_next;

  assign tick     = (cnt == CNT_MAX);
  assign step_req = step_q & ~step_prev;
  // Tick and step coinciding collapse into one advance.
  assign advance  = (tick & en) | step_req;
  assign pos      = offset;

  always_comb begin
    offset_next = offset;
    wrap_next   = 1'b0;
    if (advance) begin
      if (!dir) begin
        if (offset == POS_LAST) begin
          offset_next = '0;
          wrap_next   = 1'b1;
        end else begin
          offset_next = offset + POS_W'(1);
        end
      end else begin
        if (offset == '0) begin
          offset_next = POS_LAST;
          wrap_next   = 1'b1;
        end else begin
          offset_next = offset - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt       <= '0;
      offset    <= '0;
      msg_reg   <= {MSG_LEN{CH_BLANK}};
      step_q    <= 1'b0;
      step_prev <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      step_q    <= step;
      step_prev <= step_q;
      if (load) begin
        msg_reg <= msg;
        offset  <= '0;
        cnt     <= '0;
        wrap    <= 1'b0;
      end else begin
        cnt    <= tick ? '0 : cnt + CNT_W'(1);
        offset <= offset_next;
        wrap   <= wrap_next;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int unsigned SHIFT = NUM_DIGITS - 1 - k;

    int unsigned idx;
    logic [4:0]  code;
    logic [6:0]  seg;

    // offset and SHIFT are both below MSG_LEN, so one conditional subtract is the modulo.
    always_comb begin
      idx = 32'(offset) + SHIFT;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      code = msg_reg[5*idx +: 5];
    end

    seg7_char_decoder u_dec (
      .code (code),
      .seg  (seg)
    );

    assign hex_next[7*k +: 7] = seg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) hex <= '1;
    else       hex <= hex_next;
  end

endmodule

// File: tb/tb_hex_scroller.sv
// Bench for hex_scroller: directed scenarios plus randomized traffic on two
// parameterizations, checked against a character-level reference model.
module tb_hex_scroller;

  localparam int unsigned ND0 = 4, ML0 = 4, TD0 = 4;
  localparam int unsigned ND1 = 3, ML1 = 7, TD1 = 5;
  localparam int ND[2] = '{4, 3};
  localparam int ML[2] = '{4, 7};
  localparam int TD[2] = '{4, 5};

  localparam int C_F = 15, C_P = 17, C_G = 16, C_A = 10;

  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1, load = 1'b0, en = 1'b0, dir = 1'b0, step = 1'b0;
  logic [5*ML0-1:0] msg0 = '0;
  logic [5*ML1-1:0] msg1 = '0;
  logic [7*ND0-1:0] hex0;
  logic [7*ND1-1:0] hex1;
  logic [1:0]       pos0;
  logic [2:0]       pos1;
  logic             wrap0, wrap1;

  int total = 0;
  int bad   = 0;

  // Reference model state (character level).
  int          m_off[2];
  int          m_cnt[2];
  int          m_msg[2][8];
  bit          m_wrap[2];
  logic [27:0] m_hex[2];
  bit          m_s1, m_s2;

  hex_scroller #(.NUM_DIGITS(ND0), .MSG_LEN(ML0), .TICK_DIV(TD0)) dut0 (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .msg (msg0), .load (load), .en (en),
    .dir (dir), .step (step), .hex (hex0), .pos (pos0), .wrap (wrap0)
  );

  hex_scroller #(.NUM_DIGITS(ND1), .MSG_LEN(ML1), .TICK_DIV(TD1)) dut1 (
    .CLOCK_50 (CLOCK_50), .RESET (RESET), .msg (msg1), .load (load), .en (en),
    .dir (dir), .step (step), .hex (hex1), .pos (pos1), .wrap (wrap1)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic string lit_segments(input int c);
    case (c)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
      4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
      8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
      12: return "adef";    13: return "bcdeg";  14: return "adefg";  15: return "aefg";
      16: return "acdef";   17: return "abefg";  18: return "bcefg";  19: return "def";
      20: return "bcdef";   21: return "g";
      default: return "";
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int c);
    string s;
    logic [6:0] p;
    s = lit_segments(c);
    p = '1;
    for (int j = 0; j < s.len(); j++) p[int'(s[j]) - 97] = 1'b0;
    return p;
  endfunction

  function automatic logic [27:0] word4(input int c3, input int c2, input int c1, input int c0);
    return {seg_of(c3), seg_of(c2), seg_of(c1), seg_of(c0)};
  endfunction

  function automatic logic [27:0] render(input int i);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < ND[i]; k++)
      r[7*k +: 7] = seg_of(m_msg[i][(m_off[i] + ND[i] - 1 - k) % ML[i]]);
    return r;
  endfunction

  task automatic model_edge();
    bit req, tick;
    int prev;
    req = m_s1 && !m_s2;
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        m_off[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0; m_hex[i] = '1;
        for (int j = 0; j < 8; j++) m_msg[i][j] = 31;
      end else begin
        m_hex[i] = render(i);
        tick = (m_cnt[i] == TD[i] - 1);
        if (load) begin
          if (i == 0) for (int j = 0; j < ML0; j++) m_msg[0][j] = int'(msg0[5*j +: 5]);
          else        for (int j = 0; j < ML1; j++) m_msg[1][j] = int'(msg1[5*j +: 5]);
          m_off[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % TD[i];
          if ((tick && en) || req) begin
            prev = m_off[i];
            m_off[i]  = dir ? (prev + ML[i] - 1) % ML[i] : (prev + 1) % ML[i];
            m_wrap[i] = dir ? (prev == 0) : (prev == ML[i] - 1);
          end else begin
            m_wrap[i] = 0;
          end
        end
      end
    end
    if (RESET) begin m_s1 = 0; m_s2 = 0; end
    else begin m_s2 = m_s1; m_s1 = step; end
  endtask

  task automatic clk_cycle();
    @(posedge CLOCK_50);
    model_edge();
    #1;
  endtask

  task automatic do_load(input logic [5*ML0-1:0] v);
    load = 1'b1;
    msg0 = v;
    msg1 = 35'({$urandom(), $urandom()});
    clk_cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clk_cycle();
    clk_cycle();
    total++; if (hex0 !== {28{1'b1}}) begin bad++; $display("FAIL reset_hex0: got %h want fffffff", hex0); end
    total++; if (pos0 !== 2'd0) begin bad++; $display("FAIL reset_pos0: got %0d want 0", pos0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL reset_wrap0: got %b want 0", wrap0); end
    total++; if (hex1 !== {21{1'b1}}) begin bad++; $display("FAIL reset_hex1: got %h want 1fffff", hex1); end
    total++; if (pos1 !== 3'd0) begin bad++; $display("FAIL reset_pos1: got %0d want 0", pos1); end
    RESET = 1'b0;
  endtask

  task automatic test_load_scroll();
    logic [27:0] exp;
    en = 1'b1; dir = 1'b0; step = 1'b0;
    do_load({5'd10, 5'd16, 5'd17, 5'd15});
    clk_cycle();
    exp = word4(C_F, C_P, C_G, C_A);
    total++; if (hex0 !== exp) begin bad++; $display("FAIL scroll_fpga: got %h want %h", hex0, exp); end
    total++; if (pos0 !== 2'd0) begin bad++; $display("FAIL scroll_pos0: got %0d want 0", pos0); end
    repeat (3) clk_cycle();
    total++; if (pos0 !== 2'd1) begin bad++; $display("FAIL scroll_pos1: got %0d want 1", pos0); end
    clk_cycle();
    exp = word4(C_P, C_G, C_A, C_F);
    total++; if (hex0 !== exp) begin bad++; $display("FAIL scroll_pgaf: got %h want %h", hex0, exp); end
    repeat (4) clk_cycle();
    exp = word4(C_G, C_A, C_F, C_P);
    total++; if (hex0 !== exp) begin bad++; $display("FAIL scroll_gafp: got %h want %h", hex0, exp); end
    total++; if (pos0 !== 2'd2) begin bad++; $display("FAIL scroll_pos2: got %0d want 2", pos0); end
    total++; if (hex1 !== m_hex[1][20:0]) begin bad++; $display("FAIL scroll_hex1: got %h want %h", hex1, m_hex[1][20:0]); end
  endtask

  task automatic test_reverse_wrap();
    logic [27:0] exp;
    en = 1'b1; dir = 1'b1; step = 1'b0;
    do_load({5'd10, 5'd16, 5'd17, 5'd15});
    for (int c = 0; c < 3; c++) begin
      clk_cycle();
      total++; if (pos0 !== 2'd0 || wrap0 !== 1'b0) begin bad++; $display("FAIL rev_idle: got pos=%0d wrap=%b want pos=0 wrap=0", pos0, wrap0); end
    end
    clk_cycle();
    total++; if (pos0 !== 2'd3) begin bad++; $display("FAIL rev_pos: got %0d want 3", pos0); end
    total++; if (wrap0 !== 1'b1) begin bad++; $display("FAIL rev_wrap_pulse: got %b want 1", wrap0); end
    en = 1'b0;
    clk_cycle();
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL rev_wrap_clear: got %b want 0", wrap0); end
    exp = word4(C_A, C_F, C_P, C_G);
    total++; if (hex0 !== exp) begin bad++; $display("FAIL rev_afpg: got %h want %h", hex0, exp); end
    dir = 1'b0;
  endtask

  task automatic test_manual_step();
    en = 1'b0; dir = 1'b0; step = 1'b0;
    do_load({5'd10, 5'd16, 5'd17, 5'd15});
    repeat (6) clk_cycle();
    total++; if (pos0 !== 2'd0) begin bad++; $display("FAIL step_tick_only: got %0d want 0", pos0); end
    step = 1'b1;
    repeat (10) clk_cycle();
    step = 1'b0;
    repeat (3) clk_cycle();
    total++; if (pos0 !== 2'd1) begin bad++; $display("FAIL step_once: got %0d want 1", pos0); end
    total++; if (pos1 !== 3'(m_off[1])) begin bad++; $display("FAIL step_pos1: got %0d want %0d", pos1, m_off[1]); end
  endtask

  task automatic test_simultaneous();
    en = 1'b1; dir = 1'b0; step = 1'b0;
    do_load({5'd10, 5'd16, 5'd17, 5'd15});
    repeat (2) clk_cycle();
    step = 1'b1;
    repeat (2) clk_cycle();
    total++; if (pos0 !== 2'd1) begin bad++; $display("FAIL simul_single: got %0d want 1", pos0); end
    repeat (3) clk_cycle();
    total++; if (pos0 !== 2'd1) begin bad++; $display("FAIL simul_hold: got %0d want 1", pos0); end
    load = 1'b1;
    clk_cycle();
    load = 1'b0;
    total++; if (pos0 !== 2'd0) begin bad++; $display("FAIL simul_load: got %0d want 0", pos0); end
    total++; if (wrap0 !== 1'b0) begin bad++; $display("FAIL simul_load_wrap: got %b want 0", wrap0); end
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; dir = 1'b0; step = 1'b0;
    do_load({5'd10, 5'd16, 5'd17, 5'd15});
    repeat (8) clk_cycle();
    total++; if (pos0 !== 2'd2) begin bad++; $display("FAIL mid_pre_pos: got %0d want 2", pos0); end
    RESET = 1'b1; load = 1'b1; step = 1'b1;
    clk_cycle();
    RESET = 1'b0; load = 1'b0; step = 1'b0;
    total++; if (pos0 !== 2'd0) begin bad++; $display("FAIL mid_pos: got %0d want 0", pos0); end
    total++; if (hex0 !== {28{1'b1}}) begin bad++; $display("FAIL mid_hex0: got %h want fffffff", hex0); end
    total++; if (hex1 !== {21{1'b1}}) begin bad++; $display("FAIL mid_hex1: got %h want 1fffff", hex1); end
    clk_cycle();
    total++; if (hex0 !== {28{1'b1}}) begin bad++; $display("FAIL mid_blank_msg: got %h want fffffff", hex0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      RESET = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 15) == 0);
      msg0  = 20'($urandom());
      msg1  = 35'({$urandom(), $urandom()});
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 2) == 0) step = ~step;
      clk_cycle();
      total++; if (hex0 !== m_hex[0]) begin bad++; $display("FAIL rnd_hex0 @%0d: got %h want %h", n, hex0, m_hex[0]); end
      total++; if (pos0 !== 2'(m_off[0])) begin bad++; $display("FAIL rnd_pos0 @%0d: got %0d want %0d", n, pos0, m_off[0]); end
      total++; if (wrap0 !== m_wrap[0]) begin bad++; $display("FAIL rnd_wrap0 @%0d: got %b want %b", n, wrap0, m_wrap[0]); end
      total++; if (hex1 !== m_hex[1][20:0]) begin bad++; $display("FAIL rnd_hex1 @%0d: got %h want %h", n, hex1, m_hex[1][20:0]); end
      total++; if (pos1 !== 3'(m_off[1])) begin bad++; $display("FAIL rnd_pos1 @%0d: got %0d want %0d", n, pos1, m_off[1]); end
      total++; if (wrap1 !== m_wrap[1]) begin bad++; $display("FAIL rnd_wrap1 @%0d: got %b want %b", n, wrap1, m_wrap[1]); end
    end
    RESET = 1'b0; load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_scroll();
    test_reverse_wrap();
    test_manual_step();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of 7-segment digits driven.
REQ-002 SHALL have parameter MSG_LEN, default 8: message length in characters; legal range MSG_LEN >= NUM_DIGITS >= 1.
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000: clock cycles per scroll tick; legal range TICK_DIV >= 2.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port msg, input, 5*MSG_LEN bits: character codes, char i in bits [5i+4:5i], char 0 shown first.
REQ-007 SHALL have port load, input, 1 bit: one-cycle strobe that snapshots msg.
REQ-008 SHALL have port en, input, 1 bit: auto-scroll enable.
REQ-009 SHALL have port dir, input, 1 bit: 0 = text moves left (offset increments), 1 = text moves right (offset decrements).
REQ-010 SHALL have port step, input, 1 bit: level input; each rising edge requests one manual advance.
REQ-011 SHALL have port hex, output, 7*NUM_DIGITS bits: active-low segments a..g per digit, digit k in bits [7k+6:7k], digit 0 rightmost.
REQ-012 SHALL have port pos, output, clog2(MSG_LEN) bits (minimum 1): current offset.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when offset wraps.

Function
REQ-014 SHALL run a tick counter 0..TICK_DIV-1 that produces a one-cycle tick at TICK_DIV-1 and then wraps to 0; the counter runs regardless of en.
REQ-015 SHALL register step and detect its rising edge; the resulting advance request occurs the cycle after step is first seen high.
REQ-016 SHALL advance the offset by exactly one position on (tick AND en) OR step-edge; simultaneous events SHALL give a single advance.
REQ-017 SHALL, when dir=0, increment the offset with wrap MSG_LEN-1 -> 0; when dir=1, decrement it with wrap 0 -> MSG_LEN-1; wrap SHALL pulse on the cycle the wrapping offset is registered.
REQ-018 SHALL, on load, copy msg into an internal message register, set the offset to 0 and reset the tick counter to 0; load has priority over any same-cycle advance.
REQ-019 SHALL drive digit k with char index (offset + NUM_DIGITS-1-k) mod MSG_LEN, so the leftmost digit shows message[offset].
REQ-020 SHALL register hex with one cycle of latency after the message register or offset changes.
REQ-021 SHALL decode character codes as: 0-9 digits, 10-15 A-F, 16 G, 17 P, 18 H, 19 L, 20 U, 21 minus; codes 22-31 and 31 SHALL render blank (7'b1111111).
REQ-022 SHALL ignore changes to msg except on load.

Reset
REQ-023 SHALL, on RESET, set offset=0, tick counter=0, message register all blank (code 31), step history=0, wrap=0, and all hex bits to 1.
REQ-024 SHALL give RESET priority over load, tick and step, including when it is asserted mid-scroll.

Structure
REQ-025 SHALL place character-code constants, segment patterns and a width helper for pos in a shared package hex_scroller_pkg.
REQ-026 SHALL instantiate one combinational sub-module, seg7_char_decoder (5-bit code in, 7-bit active-low out), once per digit.

Verification
REQ-027 SHALL cover reset: assert RESET for 2 cycles -> all hex digits 7'b1111111, pos=0, wrap=0.
REQ-028 SHALL cover load and auto-scroll (NUM_DIGITS=4, MSG_LEN=4, TICK_DIV=4): load "FPGA", en=1, dir=0 -> display F,P,G,A, then P,G,A,F after 4 cycles, then G,A,F,P.
REQ-029 SHALL cover reverse wrap: dir=1 from pos=0 -> pos=3, wrap pulses one cycle, display A,F,P,G.
REQ-030 SHALL cover manual step: en=0, hold step high 10 cycles -> exactly one advance; tick alone -> no advance.
REQ-031 SHALL cover simultaneous events: step edge coincident with an enabled tick -> pos advances by 1 only; load in the same cycle -> pos=0.
REQ-032 SHALL cover reset mid-scroll: RESET at pos=2 -> next cycle pos=0 and all hex digits blank.
